automata_report_collector: RTL and testbench

//  Sink side of the automata report interface: samples the per-STE report wires of an

---
 rtl/automata_report_pkg.sv | 24 ++
 rtl/report_fifo.sv | 54 +++++
 rtl/automata_report_collector.sv | 101 ++++++++++
 tb/tb_automata_report_collector.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/automata_report_pkg.sv
// Shared types and constants for the automata report collector.
// Optional end-of-stream marker: define AUTOMATA_REPORT_END_MARKER_EN.
package automata_report_pkg;

  localparam int DEF_NUM_REPORTS = 2;
  localparam int DEF_OFFSET_W    = 32;
  localparam int REC_W           = DEF_OFFSET_W + DEF_NUM_REPORTS;
  localparam int DROP_CNT_W      = 16;

  // Record layout: {offset, reports}; reports occupy the low bits.
  localparam int REC_REPORTS_LSB = 0;

  function automatic int rec_offset_lsb(input int num_reports);
    return REC_REPORTS_LSB + num_reports;
  endfunction

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    DRAIN   = 2'd1,
    MARK    = 2'd2,
    DONE    = 2'd3
  } collector_state_t;

endpackage

// File: rtl/report_fifo.sv
// Synchronous FIFO with a registered head-of-queue output; a push into a full
// FIFO is taken only when a pop happens in the same cycle.
module report_fifo
  import automata_report_pkg::*;
#(
  parameter int WIDTH = REC_W,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      rd_next;
  logic             wr_en;
  logic             rd_en;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_en   = pop && !empty;
  assign wr_en   = push && (!full || rd_en);
  assign rd_next = rd_ptr + (AW+1)'(rd_en);

  // NOTE: the storage array has no reset; only pointers and the output register
  // need a defined value, and a resettable array costs a mux per bit.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      dout   <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
      rd_ptr <= rd_next;
      // Preload the next head; a write landing on the new head goes straight through.
      if (wr_en && (rd_next == wr_ptr)) dout <= din;
      else if (rd_next != wr_ptr)       dout <= mem[rd_next[AW-1:0]];
    end
  end

endmodule

// File: rtl/automata_report_collector.sv
// Tags non-zero automata report vectors with their symbol offset and streams them out.
// Optional end-of-stream marker FSM: define AUTOMATA_REPORT_END_MARKER_EN.
module automata_report_collector
  import automata_report_pkg::*;
#(
  parameter int NUM_REPORTS = DEF_NUM_REPORTS,
  parameter int OFFSET_W    = DEF_OFFSET_W,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   run,
  input  logic [NUM_REPORTS-1:0] report_vec,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OFFSET_W-1:0]    out_offset,
  output logic [NUM_REPORTS-1:0] out_reports,
  output logic                   overflow,
  output logic [DROP_CNT_W-1:0]  drop_count
`ifdef AUTOMATA_REPORT_END_MARKER_EN
  ,
  input  logic                   stream_end,
  output logic                   out_last
`endif
);

  localparam int REC_WIDTH  = OFFSET_W + NUM_REPORTS;
  localparam int OFFSET_LSB = rec_offset_lsb(NUM_REPORTS);

  logic [OFFSET_W-1:0]  offset_cnt;
  logic [REC_WIDTH-1:0] fifo_dout;
  logic                 capture_en;
  logic                 push;
  logic                 pop;
  logic                 full;
  logic                 empty;

  assign push = run && (|report_vec) && capture_en;
  assign pop  = !empty && out_ready;

  report_fifo #(
    .WIDTH (REC_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   ({offset_cnt, report_vec}),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty)
  );

  // The counter freezes once collection stops, so the marker offset stays stable.
  always_ff @(posedge clk) begin
    if (reset) begin
      offset_cnt <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      // NOTE: state updates use non-blocking assignments so every flop samples
      // pre-edge values regardless of statement order.
      if (run && capture_en) offset_cnt <= offset_cnt + OFFSET_W'(1);
      if (push && full && !pop) begin
        overflow <= 1'b1;
        if (drop_count != '1) drop_count <= drop_count + DROP_CNT_W'(1);
      end
    end
  end

`ifdef AUTOMATA_REPORT_END_MARKER_EN
  collector_state_t state;

  assign capture_en = (state == COLLECT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= COLLECT;
    end else begin
      unique case (state)
        COLLECT: if (stream_end) state <= DRAIN;
        DRAIN:   if (empty)      state <= MARK;
        MARK:    if (out_ready)  state <= DONE;
        DONE:    state <= DONE;
      endcase
    end
  end

  assign out_last    = (state == MARK);
  assign out_valid   = !empty || out_last;
  assign out_offset  = out_last ? offset_cnt : fifo_dout[OFFSET_LSB +: OFFSET_W];
  assign out_reports = out_last ? '0 : fifo_dout[REC_REPORTS_LSB +: NUM_REPORTS];
`else
  assign capture_en  = 1'b1;
  assign out_valid   = !empty;
  assign out_offset  = fifo_dout[OFFSET_LSB +: OFFSET_W];
  assign out_reports = fifo_dout[REC_REPORTS_LSB +: NUM_REPORTS];
`endif

endmodule

// File: tb/tb_automata_report_collector.sv
// Bench for automata_report_collector: directed cases plus random traffic against a
// queue-based model; a second instance with a 4-bit offset counter checks wrap-around.
module tb_automata_report_collector;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic [1:0]  report_vec = '0;
  logic        out_ready = 1'b0;
  logic        out_valid, overflow;
  logic [31:0] out_offset;
  logic [1:0]  out_reports;
  logic [15:0] drop_count;
  logic        out_valid4, overflow4;
  logic [3:0]  out_offset4;
  logic [1:0]  out_reports4;
  logic [15:0] drop_count4;
`ifdef AUTOMATA_REPORT_END_MARKER_EN
  logic        stream_end = 1'b0;
  logic        out_last, out_last4;
`endif

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  automata_report_collector #(.NUM_REPORTS(2), .OFFSET_W(32), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .run(run), .report_vec(report_vec),
    .out_valid(out_valid), .out_ready(out_ready), .out_offset(out_offset),
    .out_reports(out_reports), .overflow(overflow), .drop_count(drop_count)
`ifdef AUTOMATA_REPORT_END_MARKER_EN
    , .stream_end(stream_end), .out_last(out_last)
`endif
  );

  automata_report_collector #(.NUM_REPORTS(2), .OFFSET_W(4), .FIFO_DEPTH(DEPTH)) dut4 (
    .clk(clk), .reset(reset), .run(run), .report_vec(report_vec),
    .out_valid(out_valid4), .out_ready(out_ready), .out_offset(out_offset4),
    .out_reports(out_reports4), .overflow(overflow4), .drop_count(drop_count4)
`ifdef AUTOMATA_REPORT_END_MARKER_EN
    , .stream_end(stream_end), .out_last(out_last4)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue of {offset, reports} records plus sticky drop state.
  typedef struct packed { logic [31:0] off; logic [1:0] rep; } rec_t;
  rec_t        rec_q[$];
  logic [31:0] m_cnt  = '0;
  logic        m_ovf  = 1'b0;
  int          m_drop = 0;

  always @(posedge clk) begin
    if (reset) begin
      rec_q.delete();
      m_cnt  = '0;
      m_ovf  = 1'b0;
      m_drop = 0;
    end else begin
      bit popped;
      popped = (rec_q.size() != 0) && out_ready;
      if (popped) void'(rec_q.pop_front());
      if (run && report_vec != 2'b00) begin
        if (rec_q.size() < DEPTH) rec_q.push_back('{off: m_cnt, rep: report_vec});
        else begin
          m_ovf = 1'b1;
          if (m_drop < 65535) m_drop++;
        end
      end
      if (run) m_cnt = m_cnt + 32'd1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_valid", out_valid, rec_q.size() != 0);
      check("m_valid4", out_valid4, rec_q.size() != 0);
      check("m_overflow", overflow, m_ovf);
      check("m_drop_count", drop_count, m_drop);
      check("m_drop_count4", drop_count4, m_drop);
`ifdef AUTOMATA_REPORT_END_MARKER_EN
      check("m_last", out_last, 1'b0);
`endif
      if (rec_q.size() != 0) begin
        check("m_offset", out_offset, rec_q[0].off);
        check("m_reports", out_reports, rec_q[0].rep);
        check("m_offset4", out_offset4, rec_q[0].off[3:0]);
        check("m_reports4", out_reports4, rec_q[0].rep);
      end
    end
  end

  task automatic cyc(input logic r, input logic [1:0] v, input logic rdy, input logic rst);
    reset = rst; run = r; report_vec = v; out_ready = rdy;
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    // Reset state
    cyc(0, 2'b00, 0, 1);
    chk_en = 1'b1;
    check("rst_valid", out_valid, 1'b0);
    check("rst_offset", out_offset, 32'd0);
    check("rst_reports", out_reports, 2'b00);
    check("rst_overflow", overflow, 1'b0);
    check("rst_drop", drop_count, 16'd0);

    // Five symbols, report only on the third -> offset 2
    for (int i = 1; i <= 5; i++) cyc(1, (i == 3) ? 2'b01 : 2'b00, 0, 0);
    check("t1_valid", out_valid, 1'b1);
    check("t1_offset", out_offset, 32'd2);
    check("t1_reports", out_reports, 2'b01);

    // Idle cycles ignore report_vec and hold the counter
    for (int i = 0; i < 4; i++) cyc(0, 2'b11, 0, 0);
    cyc(1, 2'b10, 0, 0);
    cyc(0, 2'b00, 1, 0);
    check("t2_offset", out_offset, 32'd5);
    check("t2_reports", out_reports, 2'b10);

    // Overflow: 17 reporting symbols into a stalled 16-deep FIFO
    cyc(0, 2'b00, 0, 1);
    for (int i = 0; i < 17; i++) cyc(1, 2'b11, 0, 0);
    check("t3_overflow", overflow, 1'b1);
    check("t3_drop", drop_count, 16'd1);
    for (int i = 0; i < 16; i++) begin
      check("t3_drain_valid", out_valid, 1'b1);
      check("t3_drain_offset", out_offset, 32'(i));
      cyc(0, 2'b00, 1, 0);
    end
    check("t3_empty", out_valid, 1'b0);

    // Full FIFO with simultaneous push and pop: nothing dropped
    cyc(0, 2'b00, 0, 1);
    for (int i = 0; i < 16; i++) cyc(1, 2'b01, 0, 0);
    cyc(1, 2'b11, 1, 0);
    check("t4_overflow", overflow, 1'b0);
    check("t4_drop", drop_count, 16'd0);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) n++;
      cyc(0, 2'b00, 1, 0);
    end
    check("t4_occupancy", n, 16);

    // Offset wrap on the 4-bit instance
    cyc(0, 2'b00, 0, 1);
    for (int i = 1; i <= 18; i++) cyc(1, (i == 18) ? 2'b10 : 2'b00, 0, 0);
    check("t5_offset4", out_offset4, 4'd1);
    check("t5_offset32", out_offset, 32'd17);

    // Random traffic with phases of back-pressure and occasional reset
    for (int i = 0; i < 4000; i++) begin
      logic rdy;
      rdy = ((i / 64) % 3 == 1) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
      cyc($urandom_range(0, 3) != 0, 2'($urandom), rdy, $urandom_range(0, 999) == 0);
    end

`ifdef AUTOMATA_REPORT_END_MARKER_EN
    begin
      rec_t got[$];
      chk_en = 1'b0;
      cyc(0, 2'b00, 0, 1);
      for (int i = 1; i <= 10; i++) cyc(1, (i % 3 == 2) ? 2'b01 : 2'b00, 0, 0);
      stream_end = 1'b1;
      cyc(0, 2'b00, 0, 0);
      stream_end = 1'b0;
      for (int i = 0; i < 30 && got.size() < 4; i++) begin
        if (out_valid) got.push_back('{off: out_offset, rep: out_reports});
        if (out_valid && out_last) check("t6_last_pos", got.size(), 4);
        cyc(0, 2'b00, 1, 0);
      end
      check("t6_count", got.size(), 4);
      if (got.size() == 4) begin
        check("t6_r0", got[0].off, 32'd1);
        check("t6_r1", got[1].off, 32'd4);
        check("t6_r2", got[2].off, 32'd7);
        check("t6_marker_off", got[3].off, 32'd10);
        check("t6_marker_rep", got[3].rep, 2'b00);
      end
      for (int i = 0; i < 5; i++) cyc(1, 2'b11, 1, 0);
      check("t6_done_quiet", out_valid, 1'b0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
